aes_ctr_xor: RTL and testbench

AES_CTR_XOR -- requirements
Module: aes_ctr_xor

---
 rtl/aes_ctr_xor.sv | 171 +++++++++++++++++
 tb/tb_aes_ctr_xor.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_ctr_xor.sv
// AES-CTR front end: builds {nonce,ctr} blocks for an external LAT-deep AES pipe and XORs the keystream into a FWFT output FIFO.
// Latency LAT+1 cycles from acceptance to ct_valid; credit-based pt_ready never stalls the pipe. Optional macro: AES_CTR_XOR_WRAP_ERR_EN.

module aes_ctr_xor_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wrVld,
    input  logic [WIDTH-1:0] wrDat,
    output logic             rdVld,
    input  logic             rdRdy,
    output logic [WIDTH-1:0] rdDat
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic [CW-1:0]    count;
    logic             push;
    logic             pop;
    logic             full;

    function automatic logic [AW-1:0] nextPtr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign rdVld = (count != '0);
    assign full  = (count == CW'(DEPTH));
    assign pop   = rdVld && rdRdy;
    // A write into a full FIFO is only legal alongside a pop of the head.
    assign push  = wrVld && (!full || pop);
    assign rdDat = mem[rdPtr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= nextPtr(wrPtr);
            if (pop)  rdPtr <= nextPtr(rdPtr);
            if (push && !pop)
                count <= count + CW'(1);
            else if (!push && pop)
                count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wrPtr] <= wrDat;
    end
endmodule

module aes_ctr_xor #(
    parameter int LAT        = 11,
    parameter int FIFO_DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [95:0]  nonce_in,
    input  logic         ctr_load,
    input  logic [31:0]  ctr_init,
    input  logic         pt_valid,
    output logic         pt_ready,
    input  logic [127:0] pt_data,
    output logic [127:0] aes_in,
    input  logic [127:0] aes_out,
    output logic         ct_valid,
    input  logic         ct_ready,
    output logic [127:0] ct_data
`ifdef AES_CTR_XOR_WRAP_ERR_EN
    ,
    output logic         ctr_wrap
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [95:0]  nonceReg;
    logic [95:0]  nonceSel;
    logic [31:0]  ctrReg;
    logic [31:0]  ctrSel;
    logic         accept;
    logic         hasCredit;
    logic         ctPop;
    logic [CW-1:0] creditUsed;
    logic [LAT-1:0] validPipe;
    logic [127:0] dataPipe [LAT];
    logic         fifoWr;
    logic [127:0] fifoWrDat;

    assign nonceSel = ctr_load ? nonce_in : nonceReg;
    assign ctrSel   = ctr_load ? ctr_init : ctrReg;
    assign aes_in   = {nonceSel, ctrSel};

    // Credits cover both the blocks inside the AES pipe and those parked in the FIFO.
    assign hasCredit = (creditUsed < CW'(FIFO_DEPTH));
    assign accept    = pt_valid && pt_ready;
    assign ctPop     = ct_valid && ct_ready;

`ifdef AES_CTR_XOR_WRAP_ERR_EN
    assign pt_ready = hasCredit && (!ctr_wrap || ctr_load);

    // A block that used counter FFFFFFFF wins over a clearing load in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ctr_wrap <= 1'b0;
        else if (accept && (ctrSel == 32'hFFFF_FFFF))
            ctr_wrap <= 1'b1;
        else if (ctr_load)
            ctr_wrap <= 1'b0;
    end
`else
    assign pt_ready = hasCredit;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nonceReg   <= '0;
            ctrReg     <= '0;
            creditUsed <= '0;
        end else begin
            if (ctr_load)
                nonceReg <= nonce_in;
            if (accept)
                ctrReg <= ctrSel + 32'd1;
            else if (ctr_load)
                ctrReg <= ctr_init;
            if (accept && !ctPop)
                creditUsed <= creditUsed + CW'(1);
            else if (!accept && ctPop)
                creditUsed <= creditUsed - CW'(1);
        end
    end

    // Valid bits track the AES pipe stage by stage so stale blocks vanish on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            validPipe <= '0;
        end else begin
            validPipe[0] <= accept;
            for (int i = 1; i < LAT; i++)
                validPipe[i] <= validPipe[i-1];
        end
    end

    always_ff @(posedge clk) begin
        dataPipe[0] <= pt_data;
        for (int i = 1; i < LAT; i++)
            dataPipe[i] <= dataPipe[i-1];
    end

    assign fifoWr    = validPipe[LAT-1];
    assign fifoWrDat = aes_out ^ dataPipe[LAT-1];

    aes_ctr_xor_fifo #(
        .WIDTH (128),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .wrVld (fifoWr),
        .wrDat (fifoWrDat),
        .rdVld (ct_valid),
        .rdRdy (ct_ready),
        .rdDat (ct_data)
    );
endmodule

// File: tb/tb_aes_ctr_xor.sv
// Scoreboard bench for aes_ctr_xor with an identity LAT-deep AES stub and a queue-based reference model.
// Model: credits = FIFO_DEPTH - outstanding blocks; each block visible on ct_valid LAT+1 cycles after its acceptance cycle.

module tb_aes_ctr_xor;
    localparam int LAT        = 11;
    localparam int FIFO_DEPTH = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [95:0]  nonce_in;
    logic         ctr_load;
    logic [31:0]  ctr_init;
    logic         pt_valid;
    logic         pt_ready;
    logic [127:0] pt_data;
    logic [127:0] aes_in;
    logic [127:0] aes_out;
    logic         ct_valid;
    logic         ct_ready;
    logic [127:0] ct_data;
`ifdef AES_CTR_XOR_WRAP_ERR_EN
    logic         ctr_wrap;
`endif

    always #5 clk = ~clk;

    aes_ctr_xor #(
        .LAT        (LAT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .nonce_in (nonce_in),
        .ctr_load (ctr_load),
        .ctr_init (ctr_init),
        .pt_valid (pt_valid),
        .pt_ready (pt_ready),
        .pt_data  (pt_data),
        .aes_in   (aes_in),
        .aes_out  (aes_out),
        .ct_valid (ct_valid),
        .ct_ready (ct_ready),
        .ct_data  (ct_data)
`ifdef AES_CTR_XOR_WRAP_ERR_EN
        ,
        .ctr_wrap (ctr_wrap)
`endif
    );

    // Identity AES stub: keystream equals the counter block, LAT registers later.
    logic [127:0] stub [LAT];
    always @(posedge clk) begin
        stub[0] <= aes_in;
        for (int i = 1; i < LAT; i++)
            stub[i] <= stub[i-1];
    end
    assign aes_out = stub[LAT-1];

    int nChecks = 0;
    int nPass   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        nChecks++;
        if (act === exp)
            nPass++;
        else
            $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    typedef struct {
        logic [127:0] ct;
        int           vis;
    } exp_t;

    exp_t         q[$];
    logic [95:0]  mNonce;
    logic [31:0]  mCtr;
    logic         mWrap;
    int           cyc       = 0;
    int           nAccepted = 0;
    int           nPopped   = 0;
    int           lastAcc   = 0;
    int           lastPop   = 0;
    logic [127:0] lastPopData;
    logic [127:0] prevPopData;

    // Monitor + reference model, evaluated mid-cycle on the falling edge.
    always @(negedge clk) begin
        logic [95:0] nSel;
        logic [31:0] cSel;
        logic        expVld;
        logic        expReady;
        exp_t        e;
        cyc++;
        if (!rst_n) begin
            q.delete();
            mNonce = '0;
            mCtr   = '0;
            mWrap  = 1'b0;
            chk("reset_ct_valid", ct_valid, 1'b0);
        end else begin
            nSel = ctr_load ? nonce_in : mNonce;
            cSel = ctr_load ? ctr_init : mCtr;
            chk("aes_in", aes_in, {nSel, cSel});
            expVld = (q.size() > 0) ? (q[0].vis <= cyc) : 1'b0;
            chk("ct_valid", ct_valid, expVld);
            expReady = (q.size() < FIFO_DEPTH);
`ifdef AES_CTR_XOR_WRAP_ERR_EN
            chk("ctr_wrap", ctr_wrap, mWrap);
            expReady = expReady && (!mWrap || ctr_load);
`endif
            chk("pt_ready", pt_ready, expReady);
            if (ct_valid && ct_ready) begin
                chk("pop_has_expected", q.size() > 0, 1'b1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("ct_data", ct_data, e.ct);
                    prevPopData = lastPopData;
                    lastPopData = ct_data;
                    lastPop     = cyc;
                    nPopped++;
                end
            end
            if (pt_valid && expReady) begin
                e.ct  = {nSel, cSel} ^ pt_data;
                e.vis = cyc + LAT + 1;
                q.push_back(e);
                nAccepted++;
                lastAcc = cyc;
                mCtr = cSel + 32'd1;
                if (cSel == 32'hFFFF_FFFF)
                    mWrap = 1'b1;
                else if (ctr_load)
                    mWrap = 1'b0;
            end else if (ctr_load) begin
                mCtr  = ctr_init;
                mWrap = 1'b0;
            end
            if (ctr_load)
                mNonce = nonce_in;
        end
    end

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        ct_ready = 1'b1;
        for (int i = 0; i < 200 && q.size() > 0; i++)
            step();
        chk("drain_queue_empty", q.size(), 0);
    endtask

    int base;
    int popBase;

    initial begin
        rst_n    = 1'b0;
        pt_valid = 1'b0;
        ctr_load = 1'b0;
        ct_ready = 1'b1;
        nonce_in = '0;
        ctr_init = '0;
        pt_data  = '0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        chk("post_reset_pt_ready", pt_ready, 1'b1);
        chk("post_reset_ct_valid", ct_valid, 1'b0);

        // Single block: nonce 0, ctr 5, pt 1.
        ctr_load = 1'b1; nonce_in = '0; ctr_init = 32'd5;
        step();
        ctr_load = 1'b0; pt_valid = 1'b1; pt_data = 128'h1;
        step();
        pt_valid = 1'b0;
        drain();
        chk("s1_ct_data", lastPopData, 128'h4);
        chk("s1_latency", lastPop - lastAcc, LAT + 1);

        // Backpressure: 20 offered with ct_ready low.
        ctr_load = 1'b1; nonce_in = {$urandom(), $urandom(), $urandom()}; ctr_init = $urandom();
        step();
        ctr_load = 1'b0;
        ct_ready = 1'b0;
        base     = nAccepted;
        popBase  = nPopped;
        pt_valid = 1'b1;
        repeat (20) begin
            pt_data = rnd128();
            step();
        end
        chk("s2_accepted_16", nAccepted - base, FIFO_DEPTH);
        chk("s2_pt_ready_low", pt_ready, 1'b0);
        ct_ready = 1'b1;
        for (int i = 0; i < 200 && (nAccepted - base) < 20; i++) begin
            pt_data = rnd128();
            step();
        end
        pt_valid = 1'b0;
        chk("s2_accepted_20", nAccepted - base, 20);
        drain();
        chk("s2_popped_20", nPopped - popBase, 20);

        // Counter at FFFFFFFF, two blocks with pt 0.
        ctr_load = 1'b1; nonce_in = {$urandom(), $urandom(), $urandom()}; ctr_init = 32'hFFFF_FFFF;
        step();
        ctr_load = 1'b0; pt_valid = 1'b1; pt_data = '0;
        step();
        step();
        pt_valid = 1'b0;
`ifdef AES_CTR_XOR_WRAP_ERR_EN
        chk("s3_wrap_set", ctr_wrap, 1'b1);
        chk("s3_refused_ready", pt_ready, 1'b0);
        ctr_load = 1'b1; ctr_init = 32'd3;
        #1;
        chk("s3_ready_on_load", pt_ready, 1'b1);
        step();
        ctr_load = 1'b0;
        chk("s3_wrap_cleared", ctr_wrap, 1'b0);
        drain();
        chk("s3_last_ctr_ff", lastPopData[31:0], 32'hFFFF_FFFF);
`else
        drain();
        chk("s3_first_ctr_ff", prevPopData[31:0], 32'hFFFF_FFFF);
        chk("s3_wrapped_ctr_0", lastPopData[31:0], 32'h0);
`endif

        // Load together with an accepted block, then one more.
        pt_valid = 1'b1; ctr_load = 1'b1; ctr_init = 32'd7; pt_data = '0;
        step();
        ctr_load = 1'b0;
        step();
        pt_valid = 1'b0;
        drain();
        chk("s4_first_ctr_7", prevPopData[31:0], 32'd7);
        chk("s4_second_ctr_8", lastPopData[31:0], 32'd8);

        // Random soak.
        for (int i = 0; i < 400; i++) begin
            pt_valid = 1'($urandom_range(0, 1));
            ct_ready = ($urandom_range(0, 3) != 0);
            ctr_load = ($urandom_range(0, 31) == 0);
            ctr_init = $urandom();
            nonce_in = {$urandom(), $urandom(), $urandom()};
            pt_data  = rnd128();
            step();
        end
        pt_valid = 1'b0;
        ctr_load = 1'b0;
        drain();

        // Reset with 3 blocks in the FIFO and 5 in flight.
        ct_ready = 1'b0;
        pt_valid = 1'b1;
        repeat (3) begin
            pt_data = rnd128();
            step();
        end
        pt_valid = 1'b0;
        repeat (LAT + 2) step();
        chk("s6_fifo_loaded", ct_valid, 1'b1);
        pt_valid = 1'b1;
        repeat (5) begin
            pt_data = rnd128();
            step();
        end
        pt_valid = 1'b0;
        popBase  = nPopped;
        rst_n    = 1'b0;
        #1;
        chk("s6_async_ct_valid", ct_valid, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        #1;
        chk("s6_pt_ready_full", pt_ready, 1'b1);
        ct_ready = 1'b1;
        repeat (40) step();
        chk("s6_no_stale_pops", nPopped - popBase, 0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
